// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package disp_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
   localparam logic [15:0][6:0] GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low segment decode with per-digit blank and decimal point.
module hex7seg
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       le,
   input  logic       point,
   output logic [7:0] seg_n
);

   // Blanking only clears the glyph; the decimal point still follows point.
   assign seg_n = {~point, (le ? 7'h7F : GLYPH[nibble])};

endmodule

// File: rtl/disp_scan_n.sv
// Time-multiplexed scanner for NDIG common-anode 7-segment digits with
// optional dead time between digits and per-frame input snapshots.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | scanning stopped, all outputs off, waiting for en
//   S_ON   | anode of digit dig driven for ON_CYC cycles
//   S_DEAD | all anodes off for DEAD_CYC cycles before the next digit
module disp_scan_n
   import disp_pkg::*;
#(
   parameter int NDIG     = 8,
   parameter int ON_CYC   = 50000,
   parameter int DEAD_CYC = 500
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [4*NDIG-1:0]   data,
   input  logic [NDIG-1:0]     point,
   input  logic [NDIG-1:0]     le,
   output logic [7:0]          seg_n,
   output logic [NDIG-1:0]     an_n,
   output logic                frame
);

   localparam int CNT_MAX = (ON_CYC > DEAD_CYC) ? ((ON_CYC > 2) ? ON_CYC : 2)
                                                : ((DEAD_CYC > 2) ? DEAD_CYC : 2);
   localparam int CW = $clog2(CNT_MAX);
   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
   localparam logic [DW-1:0] DIG_LAST  = DW'(NDIG - 1);

   state_t              r_state;
   logic [DW-1:0]       r_dig;
   logic [CW-1:0]       r_cnt;
   logic [4*NDIG-1:0]   r_data;
   logic [NDIG-1:0]     r_point;
   logic [NDIG-1:0]     r_le;
   logic [7:0]          r_seg_n;
   logic [NDIG-1:0]     r_an_n;
   logic                r_frame;

   logic [3:0]          w_nibble;
   logic                w_point;
   logic                w_le;
   logic [7:0]          w_seg_n;
   logic                w_on_done;
   logic                w_dead_done;
   logic                w_advance;

   assign w_nibble    = r_data[{r_dig, 2'b00} +: 4];
   assign w_point     = r_point[r_dig];
   assign w_le        = r_le[r_dig];
   assign w_on_done   = (r_cnt == ON_LAST);
   assign w_dead_done = (r_cnt == DEAD_LAST);
   assign w_advance   = ((r_state == S_ON) && w_on_done && (DEAD_CYC == 0)) ||
                        ((r_state == S_DEAD) && w_dead_done);

   hex7seg u_hex7seg (
      .nibble (w_nibble),
      .le     (w_le),
      .point  (w_point),
      .seg_n  (w_seg_n)
   );

   // Outputs are registered from the current state, so anode and segments
   // always move together one cycle behind the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_dig   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_point <= '0;
         r_le    <= '0;
         r_seg_n <= SEG_OFF;
         r_an_n  <= '1;
         r_frame <= 1'b0;
      end else if (!en) begin
         r_state <= S_IDLE;
         r_dig   <= '0;
         r_cnt   <= '0;
         r_seg_n <= SEG_OFF;
         r_an_n  <= '1;
         r_frame <= 1'b0;
      end else begin
         r_frame <= 1'b0;
         r_seg_n <= (r_state == S_ON) ? w_seg_n : SEG_OFF;
         r_an_n  <= (r_state == S_ON) ? ~(NDIG'(1) << r_dig) : '1;
         case (r_state)
            S_IDLE: begin
               r_data  <= data;
               r_point <= point;
               r_le    <= le;
               r_frame <= 1'b1;
               r_dig   <= '0;
               r_cnt   <= '0;
               r_state <= S_ON;
            end
            S_ON: begin
               if (w_on_done) begin
                  r_cnt <= '0;
                  if (DEAD_CYC > 0) r_state <= S_DEAD;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DEAD: begin
               if (w_dead_done) r_cnt <= '0;
               else             r_cnt <= r_cnt + CW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_advance) begin
            r_state <= S_ON;
            if (r_dig == DIG_LAST) begin
               r_dig   <= '0;
               r_data  <= data;
               r_point <= point;
               r_le    <= le;
               r_frame <= 1'b1;
            end else begin
               r_dig <= r_dig + DW'(1);
            end
         end
      end
   end

   assign seg_n = r_seg_n;
   assign an_n  = r_an_n;
   assign frame = r_frame;

endmodule

// File: tb/tb_disp_scan_n.sv
// Bench for disp_scan_n: main instance 8/4/2, a no-dead-time instance and a
// single-digit instance share the stimulus.
module tb_disp_scan_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] data;
   logic [7:0]  point;
   logic [7:0]  le;

   logic [7:0]  seg_n,  seg_n0, seg_n1;
   logic [7:0]  an_n,   an_n0;
   logic [0:0]  an_n1;
   logic        frame,  frame0, frame1;

   always #5 clk = ~clk;

   disp_scan_n #(.NDIG(8), .ON_CYC(4), .DEAD_CYC(2)) u_dut (
      .clk(clk), .rst(rst), .en(en), .data(data), .point(point), .le(le),
      .seg_n(seg_n), .an_n(an_n), .frame(frame));

   disp_scan_n #(.NDIG(8), .ON_CYC(4), .DEAD_CYC(0)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .data(data), .point(point), .le(le),
      .seg_n(seg_n0), .an_n(an_n0), .frame(frame0));

   disp_scan_n #(.NDIG(1), .ON_CYC(4), .DEAD_CYC(2)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .data(data[3:0]), .point(point[0:0]), .le(le[0:0]),
      .seg_n(seg_n1), .an_n(an_n1), .frame(frame1));

   typedef struct { logic frm; logic [7:0] an; logic [7:0] seg; } exp_t;
   typedef struct { int pos; logic [3:0] nib; logic pt; logic le; logic [7:0] seg; } vec_t;

   exp_t sb[$];
   vec_t vecs[19];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_an(input logic [7:0] want, input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk);
         n++;
         if (an_n == want) ok = 1'b1;
      end
   endtask

   task automatic restart();
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
   endtask

   task automatic sb_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({name, "_frame"}, {31'd0, frame}, {31'd0, e.frm});
         chk({name, "_an"},    {24'd0, an_n},  {24'd0, e.an});
         chk({name, "_seg"},   {24'd0, seg_n}, {24'd0, e.seg});
      end
   endtask

   function automatic logic frm_of(input int w);
      return (w == 0) ? frame0 : frame1;
   endfunction

   // Cycles from one frame pulse of the chosen instance to the next; -1 on timeout.
   task automatic period(input int w, output int per);
      int n = 0;
      per = -1;
      do begin @(negedge clk); n++; end while (!frm_of(w) && n < 200);
      if (frm_of(w)) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!frm_of(w) && n < 200);
         if (frm_of(w)) per = n;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit       ok;
      int       per;
      int       ff_cnt;
      int       fe_cnt;
      int       n;
      logic [7:0] prev;
      logic [7:0] nxt;
      logic [7:0] want;
      bit       bad;
      exp_t     e;

      vecs[0]  = '{0, 4'h0, 1'b0, 1'b0, 8'hC0};
      vecs[1]  = '{1, 4'h1, 1'b0, 1'b0, 8'hF9};
      vecs[2]  = '{2, 4'h2, 1'b0, 1'b0, 8'hA4};
      vecs[3]  = '{3, 4'h3, 1'b0, 1'b0, 8'hB0};
      vecs[4]  = '{4, 4'h4, 1'b0, 1'b0, 8'h99};
      vecs[5]  = '{5, 4'h5, 1'b0, 1'b0, 8'h92};
      vecs[6]  = '{6, 4'h6, 1'b0, 1'b0, 8'h82};
      vecs[7]  = '{7, 4'h7, 1'b0, 1'b0, 8'hF8};
      vecs[8]  = '{0, 4'h8, 1'b1, 1'b0, 8'h00};
      vecs[9]  = '{1, 4'h9, 1'b0, 1'b0, 8'h90};
      vecs[10] = '{2, 4'hA, 1'b0, 1'b0, 8'h88};
      vecs[11] = '{3, 4'hB, 1'b0, 1'b0, 8'h83};
      vecs[12] = '{4, 4'hC, 1'b0, 1'b0, 8'hC6};
      vecs[13] = '{5, 4'hD, 1'b0, 1'b0, 8'hA1};
      vecs[14] = '{6, 4'hE, 1'b0, 1'b0, 8'h86};
      vecs[15] = '{7, 4'hF, 1'b0, 1'b0, 8'h8E};
      vecs[16] = '{3, 4'h8, 1'b0, 1'b1, 8'hFF};
      vecs[17] = '{5, 4'h2, 1'b1, 1'b1, 8'h7F};
      vecs[18] = '{6, 4'h3, 1'b1, 1'b0, 8'h30};

      rst = 1'b1; en = 1'b0; data = 32'h76543210; point = 8'h00; le = 8'h00;
      @(negedge clk); @(negedge clk);
      chk("rst_seg", {24'd0, seg_n}, 32'hFF);
      chk("rst_an",  {24'd0, an_n},  32'hFF);
      chk("rst_frame", {31'd0, frame}, 32'd0);

      // First frame after reset: exact cycle sequence.
      rst = 1'b0;
      @(negedge clk);
      en = 1'b1;
      sb.push_back('{1'b1, 8'hFF, 8'hFF});
      for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 8'hFE, 8'hC0});
      for (int k = 0; k < 2; k++) sb.push_back('{1'b0, 8'hFF, 8'hFF});
      sb.push_back('{1'b0, 8'hFD, 8'hF9});
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         sb_check("first_frame");
      end

      // Glyph / point / blank table, one digit position per vector.
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         en = 1'b0;
         data = 32'h11111111;
         data[vecs[i].pos*4 +: 4] = vecs[i].nib;
         point = 8'hFF;
         point[vecs[i].pos] = vecs[i].pt;
         le = 8'hFF;
         le[vecs[i].pos] = vecs[i].le;
         @(negedge clk);
         en = 1'b1;
         want = ~(8'b1 << vecs[i].pos);
         sb.push_back('{1'b0, want, vecs[i].seg});
         wait_an(want, 100, ok);
         chk($sformatf("vec%0d_wait", i), {31'd0, ok}, 32'd1);
         e = sb.pop_front();
         chk($sformatf("vec%0d_seg", i), {24'd0, seg_n}, {24'd0, e.seg});
      end

      // No tearing: data changed mid-frame shows only after the wrap.
      data = 32'h76543210; point = 8'h00; le = 8'h00;
      restart();
      wait_an(8'hFB, 100, ok);
      chk("tear_wait_d2", {31'd0, ok}, 32'd1);
      data = 32'h89ABCDEF;
      wait_an(8'hF7, 20, ok);
      chk("tear_d3_seg", {24'd0, seg_n}, 32'hB0);
      wait_an(8'h7F, 40, ok);
      chk("tear_d7_seg", {24'd0, seg_n}, 32'hF8);
      n = 0;
      do begin @(negedge clk); n++; end while (!frame && n < 20);
      chk("tear_frame", {31'd0, frame}, 32'd1);
      wait_an(8'hFE, 10, ok);
      chk("tear_new_d0", {24'd0, seg_n}, 32'h8E);
      wait_an(8'hFD, 10, ok);
      chk("tear_new_d1", {24'd0, seg_n}, 32'h86);

      // en dropped during dead time of digit 5.
      data = 32'h76543210;
      restart();
      wait_an(8'hDF, 100, ok);
      chk("drop_wait_d5", {31'd0, ok}, 32'd1);
      wait_an(8'hFF, 10, ok);
      chk("drop_wait_dead", {31'd0, ok}, 32'd1);
      en = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (an_n !== 8'hFF || seg_n !== 8'hFF || frame !== 1'b0) bad = 1'b1;
      end
      chk("drop_idle", {31'd0, bad}, 32'd0);
      en = 1'b1;
      @(negedge clk);
      chk("reen_frame", {31'd0, frame}, 32'd1);
      @(negedge clk);
      chk("reen_an", {24'd0, an_n}, 32'hFE);
      chk("reen_seg", {24'd0, seg_n}, 32'hC0);

      // No-dead-time instance: frame period and digit stepping.
      restart();
      period(0, per);
      chk("nodead_period", per, 32);
      ff_cnt = 0; fe_cnt = 0; prev = 8'h00; nxt = 8'h00;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (an_n0 == 8'hFF) ff_cnt++;
         if (an_n0 == 8'hFE) fe_cnt++;
         if (prev == 8'hFE && an_n0 != 8'hFE && nxt == 8'h00) nxt = an_n0;
         prev = an_n0;
      end
      chk("nodead_ff_cycles", ff_cnt, 0);
      chk("nodead_fe_cycles", fe_cnt, 4);
      chk("nodead_next_an", {24'd0, nxt}, 32'hFD);

      // Single-digit instance.
      period(1, per);
      chk("ndig1_period", per, 6);
      n = 0;
      do begin @(negedge clk); n++; end while (an_n1 !== 1'b0 && n < 20);
      chk("ndig1_seg", {24'd0, seg_n1}, 32'hC0);

      // Asynchronous reset in the middle of an ON period.
      data = 32'h76543210;
      restart();
      wait_an(8'hFE, 10, ok);
      chk("arst_wait_on", {31'd0, ok}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_seg", {24'd0, seg_n}, 32'hFF);
      chk("arst_an",  {24'd0, an_n},  32'hFF);
      chk("arst_frame", {31'd0, frame}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_rel_frame", {31'd0, frame}, 32'd1);
      @(negedge clk);
      chk("arst_rel_an", {24'd0, an_n}, 32'hFE);
      chk("arst_rel_seg", {24'd0, seg_n}, 32'hC0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
